// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes (also used by the
// ALU control decoder), FSM state encoding and a small op-class helper.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b0001;
    localparam alu_op_t ALU_AND  = 4'b0011;
    localparam alu_op_t ALU_OR   = 4'b0100;
    localparam alu_op_t ALU_XOR  = 4'b0101;
    localparam alu_op_t ALU_SLT  = 4'b0110;
    localparam alu_op_t ALU_SLL  = 4'b1000;
    localparam alu_op_t ALU_SLTU = 4'b1001;
    localparam alu_op_t ALU_SRL  = 4'b1010;
    localparam alu_op_t ALU_SRA  = 4'b1011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift_op(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue logic and the execute-stage ALU.
// master = requester/consumer side, slave = the ALU itself.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, alu_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );

endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter. A start pulse loads the operand,
// amount and shift kind; each following cycle shifts by one. done is high
// in the cycle whose shift is the last, and value then holds the final word.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_t         kind_in,
    input  logic [XLEN-1:0] data,
    input  logic [SHW-1:0]  amount,
    output logic            done,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;
    alu_op_t         kind;
    logic [XLEN-1:0] shifted;

    // One-bit step of the latched shift kind; SRA replicates the sign bit.
    always_comb begin
        shifted = acc;
        case (kind)
            ALU_SLL: shifted = {acc[XLEN-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, acc[XLEN-1:1]};
            default: shifted = {acc[XLEN-1], acc[XLEN-1:1]};
        endcase
    end

    // Load on start, then shift and count down until the counter empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            kind <= ALU_SLL;
        end else if (start) begin
            acc  <= data;
            cnt  <= amount;
            kind <= kind_in;
        end else if (cnt != '0) begin
            acc <= shifted;
            cnt <= cnt - SHW'(1);
        end
    end

    assign done  = (cnt == SHW'(1));
    assign value = shifted;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides. Simple ops finish in one
// registered cycle; shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN
// is defined, in which case a barrel shifter makes every op single-cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);

    localparam int SHW = $clog2(XLEN);

    logic [1:0]      state;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            accept;
    logic            shift_req;
    logic            shift_done;
    logic [XLEN-1:0] shift_value;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;

    assign shamt  = bus.op_b[SHW-1:0];
    assign accept = bus.in_valid && bus.in_ready;

    // Accept from IDLE, or from DONE in the same cycle the result is taken.
    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

    // Single-cycle result for everything except multi-cycle iterative shifts.
    always_comb begin
        alu_out = '0;
        case (bus.alu_control)
            ALU_ADD:  alu_out = bus.op_a + bus.op_b;
            ALU_SUB:  alu_out = bus.op_a - bus.op_b;
            ALU_AND:  alu_out = bus.op_a & bus.op_b;
            ALU_OR:   alu_out = bus.op_a | bus.op_b;
            ALU_XOR:  alu_out = bus.op_a ^ bus.op_b;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_out = bus.op_a << shamt;
            ALU_SRL:  alu_out = bus.op_a >> shamt;
            ALU_SRA:  alu_out = $signed(bus.op_a) >>> shamt;
`else
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_out = bus.op_a;
`endif
            default:  alu_out = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign shift_req   = 1'b0;
    assign shift_done  = 1'b0;
    assign shift_value = '0;
    assign bus.busy    = 1'b0;
`else
    assign shift_req = accept && is_shift_op(bus.alu_control) && (shamt != '0);
    assign bus.busy  = (state == ST_SHIFT);

    alu_shift_iter #(
        .XLEN (XLEN)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (shift_req),
        .kind_in (bus.alu_control),
        .data    (bus.op_a),
        .amount  (shamt),
        .done    (shift_done),
        .value   (shift_value)
    );
`endif

    // Control FSM: registers the result and holds it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (shift_req) begin
                            state <= ST_SHIFT;
                        end else begin
                            result_q <= alu_out;
                            zero_q   <= (alu_out == '0);
                            state    <= ST_DONE;
                        end
                    end else if ((state == ST_DONE) && bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) begin
                        result_q <= shift_value;
                        zero_q   <= (shift_value == '0);
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_control code produced by the ALU control decoder. It also takes two XLEN-bit operands.
- Simple ops (ADD/SUB/logic/compare) complete in one registered cycle.
- Shifts run iteratively, one bit per cycle, to save area.
- Valid/ready handshakes on both sides let the core stall around multi-cycle shifts. Result plus zero/branch flags feed writeback and branch resolution.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, minimum 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alu_control  in  4  operation code; encoding listed under Behaviour.
- op_a  in  XLEN  operand A; rs1 value.
- op_b  in  XLEN  operand B; rs2 value or immediate. op_b[SHW-1:0] is the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0; registered with result.
- busy  out  1  iterative shift in progress.

Behaviour:
- Codes:
  - 0000 ADD, 0001 SUB, 0011 AND, 0100 OR, 0101 XOR.
  - 0110 SLT (signed), 1001 SLTU.
  - 1000 SLL, 1010 SRL, 1011 SRA.
  - Any other code: result 0, handled as a simple op.
- Arithmetic wraps modulo 2^XLEN, with no overflow flag. SLT/SLTU return 1 or 0, zero-extended.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, busy=0. in_ready is combinational.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1.
    - Accept (in_valid=1) of a simple op: compute, register result and zero, go to DONE.
    - Accept of a shift with shamt=0: result=op_a, go to DONE.
    - Accept of a shift with shamt!=0: acc=op_a, cnt=shamt, latch the shift kind, go to SHIFT.
  - SHIFT: busy=1, in_ready=0, out_valid=0.
    - Each cycle: shift acc by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and decrement cnt.
    - When cnt reaches 1, the final shift writes result/zero and the FSM goes to DONE.
  - DONE: out_valid=1; result and zero stay stable until out_valid && out_ready.
    - in_ready = out_ready, giving back-to-back throughput.
    - Handshake completes and in_valid=0: go to IDLE.
    - Handshake completes and in_valid=1: the new op is accepted in the same cycle and processed exactly as from IDLE.
- Latency from accept to out_valid:
  - Simple ops and shamt=0: 1 cycle.
  - Shift by n (n≥1): n+1 cycles.
- Sustained throughput for simple ops with out_ready=1: one op per cycle.
- Operands are captured at accept; later changes to op_a/op_b/alu_control have no effect.
- in_valid while in SHIFT, or in DONE with out_ready=0, is not accepted. The requester must hold its request.
- Asynchronous reset at any point, including mid-SHIFT, aborts the operation and returns all outputs to reset values. The aborted result never appears.

Optional Feature:
- ALU_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter. Every op has latency 1, SHIFT state is never entered, and busy is tied to 0.
- Undefined: iterative shifter as described above.
- Port list is identical in both builds.

Decomposition:
- Package alu_pkg:
  - ALU op code localparams (ALU_ADD=4'b0000 … ALU_SRA=4'b1011), shared with the ALU control decoder.
  - FSM state encoding (IDLE/SHIFT/DONE).
- One natural sub-module: alu_shift_iter.
  - Accumulator, counter, and the per-cycle 1-bit shift.
  - start/done interface.
  - Replaced by combinational shift logic under ALU_FAST_SHIFT_EN.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 → next cycle: out_valid=1, result=0x80000000, zero=0. SUB 5-5 → result=0, zero=1.
- SLT op_a=0xFFFFFFFF, op_b=1 → result=1. SLTU with the same operands → result=0.
- SRA op_a=0x80000000, op_b=4 → busy for 4 cycles, out_valid on cycle 5, result=0xF8000000. SRL with the same operands → 0x08000000. SLL 1<<31 → 0x80000000 after 32 cycles. Shift with shamt=0 → 1 cycle, result=op_a.
- Backpressure: ADD result 3 with out_ready=0 for 3 cycles → result/out_valid held stable and in_ready=0. out_ready=1 with a new in_valid → handshake and accept in the same cycle; next result appears the following cycle.
- Assert rst in the 2nd cycle of SLL by 10 → out_valid=0, busy=0, result=0 immediately. After release, ADD 2+2 → 4 in 1 cycle.
- With ALU_FAST_SHIFT_EN defined: SRA 0x80000000 by 31 → result 0xFFFFFFFF 1 cycle after accept, busy never asserted.
